// File: rtl/xbar_csr_pkg.sv
// Shared definitions for the crossbar APB register block:
// register offsets, bit positions, reset values and APB phase encoding.
package xbar_csr_pkg;

    localparam logic [11:0] OFF_CTRL        = 12'h000;
    localparam logic [11:0] OFF_SLV_EN      = 12'h004;
    localparam logic [11:0] OFF_ERR_STAT    = 12'h008;
    localparam logic [11:0] OFF_AW_ERR_ADDR = 12'h00C;
    localparam logic [11:0] OFF_AR_ERR_ADDR = 12'h010;
    localparam logic [11:0] OFF_AW_CNT      = 12'h014;
    localparam logic [11:0] OFF_AR_CNT      = 12'h018;
    localparam logic [11:0] OFF_IRQ_EN      = 12'h01C;
    localparam logic [11:0] OFF_AW_SID      = 12'h020;
    localparam logic [11:0] OFF_AR_SID      = 12'h024;

    localparam int CTRL_ARB     = 0;
    localparam int CTRL_CNT_EN  = 1;
    localparam int CTRL_CNT_CLR = 2;

    localparam int ERR_AR = 0;
    localparam int ERR_AW = 1;

    localparam logic       RST_ARB    = 1'b0;
    localparam logic       RST_CNT_EN = 1'b1;
    localparam logic [1:0] RST_IRQ_EN = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_access_e;

    function automatic logic is_ro(input logic [11:0] off);
        return (off == OFF_AW_ERR_ADDR) || (off == OFF_AR_ERR_ADDR) ||
               (off == OFF_AW_CNT)      || (off == OFF_AR_CNT)      ||
               (off == OFF_AW_SID)      || (off == OFF_AR_SID);
    endfunction

endpackage

// File: rtl/xbar_csr_sat_cnt.sv
// 32-bit saturating event counter; clr wins over inc.
// Ports: clk, rst, en (count enable), clr, inc (event pulse), cnt (value).
module xbar_csr_sat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && inc && !(&cnt)) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/apb_xbar_csr.sv
// APB3 control/status registers for the AXI crossbar: arbiter mode,
// slave enables, sticky decode-error flags with first-address capture,
// handshake counters and a level interrupt.
// Ports: clk/rst, APB slave (psel..pslverr), error and handshake event
// inputs, live SID buffers, arbiter_type/slv_en controls and irq.
module apb_xbar_csr
    import xbar_csr_pkg::*;
#(
    parameter int          NUM_SLV   = 3,
    parameter int          NUM_MST   = 4,
    parameter int          SID_W     = 8,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [31:0]              paddr,
    input  logic [31:0]              pwdata,
    output logic [31:0]              prdata,
    output logic                     pready,
    output logic                     pslverr,
    input  logic                     aw_err,
    input  logic [ADDR_W-1:0]        aw_err_addr,
    input  logic                     ar_err,
    input  logic [ADDR_W-1:0]        ar_err_addr,
    input  logic                     aw_hs,
    input  logic                     ar_hs,
    input  logic [NUM_MST*SID_W-1:0] aw_sid_buf,
    input  logic [NUM_MST*SID_W-1:0] ar_sid_buf,
    output logic                     arbiter_type,
    output logic [NUM_SLV-1:0]       slv_en,
    output logic                     irq
);

    logic [11:0]       off;
    logic              hit;
    logic              mapped;
    logic              acc_err;
    logic [31:0]       rd_data;

    logic              cnt_en;
    logic [1:0]        irq_en;
    logic              ar_flag;
    logic              aw_flag;
    logic [ADDR_W-1:0] ar_addr;
    logic [ADDR_W-1:0] aw_addr;
    logic [31:0]       aw_cnt;
    logic [31:0]       ar_cnt;

    logic              wr_en;
    logic              wr_ctrl;
    logic              wr_slv;
    logic              wr_err;
    logic              wr_irq;
    logic              cnt_clr;
    logic [1:0]        w1c;
    logic              ar_flag_n;
    logic              aw_flag_n;
    logic              ar_cap;
    logic              aw_cap;

    // Upper write-data bits beyond the widest field are don't-care.
    logic unused_bits;
    assign unused_bits = &{1'b0, pwdata};

    always_comb begin
        off     = paddr[11:0];
        hit     = (paddr[31:12] == BASE_ADDR[31:12]);
        mapped  = 1'b0;
        rd_data = '0;
        case (off)
            OFF_CTRL: begin
                mapped  = 1'b1;
                rd_data[CTRL_ARB]    = arbiter_type;
                rd_data[CTRL_CNT_EN] = cnt_en;
            end
            OFF_SLV_EN: begin
                mapped  = 1'b1;
                rd_data = 32'(slv_en);
            end
            OFF_ERR_STAT: begin
                mapped  = 1'b1;
                rd_data[ERR_AR] = ar_flag;
                rd_data[ERR_AW] = aw_flag;
            end
            OFF_AW_ERR_ADDR: begin
                mapped  = 1'b1;
                rd_data = 32'(aw_addr);
            end
            OFF_AR_ERR_ADDR: begin
                mapped  = 1'b1;
                rd_data = 32'(ar_addr);
            end
            OFF_AW_CNT: begin
                mapped  = 1'b1;
                rd_data = aw_cnt;
            end
            OFF_AR_CNT: begin
                mapped  = 1'b1;
                rd_data = ar_cnt;
            end
            OFF_IRQ_EN: begin
                mapped  = 1'b1;
                rd_data = 32'(irq_en);
            end
            OFF_AW_SID: begin
                mapped  = 1'b1;
                rd_data = 32'(aw_sid_buf);
            end
            OFF_AR_SID: begin
                mapped  = 1'b1;
                rd_data = 32'(ar_sid_buf);
            end
            default: begin
                mapped  = 1'b0;
                rd_data = '0;
            end
        endcase
        // Offsets in the map are word aligned, so a byte offset never matches.
        acc_err = !hit || !mapped || (pwrite && is_ro(off));
    end

    assign pready  = psel & penable;
    assign pslverr = psel & penable & acc_err;

    assign wr_en   = psel & penable & pwrite & ~acc_err;
    assign wr_ctrl = wr_en & (off == OFF_CTRL);
    assign wr_slv  = wr_en & (off == OFF_SLV_EN);
    assign wr_err  = wr_en & (off == OFF_ERR_STAT);
    assign wr_irq  = wr_en & (off == OFF_IRQ_EN);
    assign cnt_clr = wr_ctrl & pwdata[CTRL_CNT_CLR];

    // A new event beats a coincident W1C; the address is taken when the
    // flag is clear or being cleared in the same cycle.
    always_comb begin
        w1c       = wr_err ? pwdata[1:0] : 2'b00;
        ar_flag_n = (ar_flag & ~w1c[ERR_AR]) | ar_err;
        aw_flag_n = (aw_flag & ~w1c[ERR_AW]) | aw_err;
        ar_cap    = ar_err & (~ar_flag | w1c[ERR_AR]);
        aw_cap    = aw_err & (~aw_flag | w1c[ERR_AW]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arbiter_type <= RST_ARB;
            cnt_en       <= RST_CNT_EN;
            slv_en       <= {NUM_SLV{1'b1}};
            irq_en       <= RST_IRQ_EN;
            ar_flag      <= 1'b0;
            aw_flag      <= 1'b0;
            ar_addr      <= '0;
            aw_addr      <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                arbiter_type <= pwdata[CTRL_ARB];
                cnt_en       <= pwdata[CTRL_CNT_EN];
            end
            if (wr_slv) begin
                slv_en <= pwdata[NUM_SLV-1:0];
            end
            if (wr_irq) begin
                irq_en <= pwdata[1:0];
            end
            ar_flag <= ar_flag_n;
            aw_flag <= aw_flag_n;
            if (ar_cap) begin
                ar_addr <= ar_err_addr;
            end
            if (aw_cap) begin
                aw_addr <= aw_err_addr;
            end
            irq <= |({aw_flag, ar_flag} & irq_en);
        end
    end

    // Read data is launched in the setup phase and held for the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            prdata <= '0;
        end else if (psel && !penable && !pwrite) begin
            prdata <= acc_err ? 32'd0 : rd_data;
        end
    end

    xbar_csr_sat_cnt u_aw_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .inc (aw_hs),
        .cnt (aw_cnt)
    );

    xbar_csr_sat_cnt u_ar_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .inc (ar_hs),
        .cnt (ar_cnt)
    );

endmodule

// File: tb/tb_apb_xbar_csr.sv
// Directed self-checking bench for apb_xbar_csr.
// Drives APB reads/writes and event pulses on negedges, samples after.
module tb_apb_xbar_csr;
    import xbar_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        aw_err, ar_err, aw_hs, ar_hs;
    logic [31:0] aw_err_addr, ar_err_addr;
    logic [31:0] aw_sid_buf, ar_sid_buf;
    logic        arbiter_type;
    logic [2:0]  slv_en;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    apb_access_e ph;
    always_comb begin
        ph = IDLE;
        if (psel) ph = penable ? ACCESS : SETUP;
    end

    always #5 clk = ~clk;

    apb_xbar_csr dut (
        .clk          (clk),
        .rst          (rst),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .aw_err       (aw_err),
        .aw_err_addr  (aw_err_addr),
        .ar_err       (ar_err),
        .ar_err_addr  (ar_err_addr),
        .aw_hs        (aw_hs),
        .ar_hs        (ar_hs),
        .aw_sid_buf   (aw_sid_buf),
        .ar_sid_buf   (ar_sid_buf),
        .arbiter_type (arbiter_type),
        .slv_en       (slv_en),
        .irq          (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        chk("rd_pready", {31'd0, pready}, {31'd0, ph == ACCESS});
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic ev_err, input logic [31:0] ev_addr,
                          input logic ev_hs, input logic ev_rst,
                          output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        aw_err = ev_err;
        aw_err_addr = ev_addr;
        aw_hs = ev_hs;
        rst = ev_rst;
        #1;
        e = pslverr;
        chk("wr_pready", {31'd0, pready}, {31'd0, ph == ACCESS});
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        aw_err = 1'b0; aw_hs = 1'b0; rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic e;
        apb_wr(a, d, 1'b0, 32'd0, 1'b0, 1'b0, e);
        chk("wr_ok", {31'd0, e}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_rd(a, d, e);
        chk(tag, d, exp);
        chk({tag, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic ev(input logic awe, input logic [31:0] awa,
                      input logic are, input logic [31:0] ara,
                      input logic awh, input logic arh);
        @(negedge clk);
        aw_err = awe; aw_err_addr = awa;
        ar_err = are; ar_err_addr = ara;
        aw_hs = awh; ar_hs = arh;
        @(negedge clk);
        aw_err = 1'b0; ar_err = 1'b0; aw_hs = 1'b0; ar_hs = 1'b0;
    endtask

    localparam logic [31:0] B = 32'h5000_0000;

    initial begin
        logic [31:0] d;
        logic        e;
        rst = 1'b1;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        aw_err = 0; ar_err = 0; aw_hs = 0; ar_hs = 0;
        aw_err_addr = 0; ar_err_addr = 0;
        aw_sid_buf = 32'hDEAD_BEEF; ar_sid_buf = 32'h0102_0304;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_slv_en", {29'd0, slv_en}, 32'h7);
        chk("rst_arb", {31'd0, arbiter_type}, 32'd0);

        rd_chk("slv_en_rst", B + 32'h04, 32'h7);
        rd_chk("ctrl_rst", B + 32'h00, 32'h2);
        rd_chk("aw_sid", B + 32'h20, 32'hDEAD_BEEF);
        rd_chk("ar_sid", B + 32'h24, 32'h0102_0304);

        // first error wins
        ev(1'b1, 32'h1234_0000, 1'b0, 32'd0, 1'b0, 1'b0);
        ev(1'b1, 32'h5678_0000, 1'b0, 32'd0, 1'b0, 1'b0);
        rd_chk("err_stat_aw", B + 32'h08, 32'h2);
        rd_chk("aw_addr_first", B + 32'h0C, 32'h1234_0000);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        wr(B + 32'h1C, 32'h2);
        chk("irq_latency", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_set", {31'd0, irq}, 32'd1);

        // W1C coincident with new event
        apb_wr(B + 32'h08, 32'h2, 1'b1, 32'hAAAA_0000, 1'b0, 1'b0, e);
        chk("w1c_coinc_err", {31'd0, e}, 32'd0);
        rd_chk("err_stat_keep", B + 32'h08, 32'h2);
        rd_chk("aw_addr_upd", B + 32'h0C, 32'hAAAA_0000);
        wr(B + 32'h08, 32'h2);
        rd_chk("err_stat_clr", B + 32'h08, 32'h0);
        chk("irq_clr", {31'd0, irq}, 32'd0);

        ev(1'b0, 32'd0, 1'b1, 32'h0BAD_0000, 1'b0, 1'b0);
        rd_chk("err_stat_ar", B + 32'h08, 32'h1);
        rd_chk("ar_addr", B + 32'h10, 32'h0BAD_0000);
        chk("irq_ar_masked", {31'd0, irq}, 32'd0);
        wr(B + 32'h08, 32'h1);

        // counters
        ev(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        ev(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        rd_chk("aw_cnt2", B + 32'h14, 32'd2);
        rd_chk("ar_cnt1", B + 32'h18, 32'd1);

        apb_wr(B + 32'h14, 32'h1, 1'b0, 32'd0, 1'b0, 1'b0, e);
        chk("ro_wr_err", {31'd0, e}, 32'd1);
        rd_chk("aw_cnt_ro", B + 32'h14, 32'd2);

        wr(B + 32'h00, 32'h0);
        ev(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        rd_chk("aw_cnt_dis", B + 32'h14, 32'd2);
        wr(B + 32'h00, 32'h2);

        @(negedge clk);
        force dut.u_aw_cnt.cnt = 32'hFFFF_FFFB;
        @(negedge clk);
        release dut.u_aw_cnt.cnt;
        aw_hs = 1'b1;
        repeat (3) @(negedge clk);
        aw_hs = 1'b0;
        rd_chk("aw_cnt_fffe", B + 32'h14, 32'hFFFF_FFFE);
        aw_hs = 1'b1;
        repeat (3) @(negedge clk);
        aw_hs = 1'b0;
        rd_chk("aw_cnt_sat", B + 32'h14, 32'hFFFF_FFFF);

        apb_wr(B + 32'h00, 32'h6, 1'b0, 32'd0, 1'b1, 1'b0, e);
        chk("clr_wr_err", {31'd0, e}, 32'd0);
        rd_chk("aw_cnt_clr", B + 32'h14, 32'd0);
        rd_chk("ar_cnt_clr", B + 32'h18, 32'd0);
        rd_chk("ctrl_clr_rd0", B + 32'h00, 32'h2);

        // error responses
        psel = 0;
        apb_rd(B + 32'h40, d, e);
        chk("unmap_err", {31'd0, e}, 32'd1);
        chk("unmap_data", d, 32'd0);
        apb_rd(32'h6000_0000, d, e);
        chk("miss_err", {31'd0, e}, 32'd1);
        chk("miss_data", d, 32'd0);
        apb_rd(B + 32'h06, d, e);
        chk("unalign_err", {31'd0, e}, 32'd1);
        apb_wr(32'h6000_0004, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, e);
        chk("miss_wr_err", {31'd0, e}, 32'd1);
        chk("miss_wr_slv", {29'd0, slv_en}, 32'h7);

        // reset during a write
        wr(B + 32'h00, 32'h3);
        chk("arb_set", {31'd0, arbiter_type}, 32'd1);
        wr(B + 32'h04, 32'h5);
        chk("slv_en_5", {29'd0, slv_en}, 32'h5);
        apb_wr(B + 32'h04, 32'h0, 1'b0, 32'd0, 1'b0, 1'b1, e);
        chk("rst_wr_slv", {29'd0, slv_en}, 32'h7);
        chk("rst_wr_arb", {31'd0, arbiter_type}, 32'd0);
        rd_chk("ctrl_after_rst", B + 32'h00, 32'h2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
